// File: rtl/cdb_broadcast_buffer.sv
// cdb_broadcast_buffer
//   Collects up to WAYS functional-unit results per cycle into a circular
//   completion queue and drains them onto the CDB in acceptance order,
//   LSB-packed. Also produces the per-way backpressure (ALU_occupied) that
//   the RS output selector uses.
//
// Ports
//   clock         system clock, all state on posedge
//   reset         synchronous, active-high
//   squash        flush on mispredict; discards all queued results
//   fu_valid      per-way FU result valid
//   fu_data       per-way result value
//   fu_prf_idx    per-way destination physical register
//   cdb_avail     CDB lanes usable this cycle (values above WAYS clip to WAYS)
//   ALU_occupied  way i must not present a result this cycle
//   CDB_valid     broadcast lane valid, LSB-packed
//   CDB_Data      broadcast value (0 on idle lanes)
//   CDB_PRF_idx   broadcast tag (0 on idle lanes)
//   count         entries currently held
module cdb_broadcast_buffer #(
    parameter int WAYS  = 3,
    parameter int XLEN  = 32,
    parameter int PRF   = 64,
    parameter int DEPTH = 8,
    localparam int TW   = $clog2(PRF),
    localparam int AW   = $clog2(WAYS) + 1,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [WAYS-1:0]            fu_valid,
    input  logic [WAYS-1:0][XLEN-1:0]  fu_data,
    input  logic [WAYS-1:0][TW-1:0]    fu_prf_idx,
    input  logic [AW-1:0]              cdb_avail,
    output logic [WAYS-1:0]            ALU_occupied,
    output logic [WAYS-1:0]            CDB_valid,
    output logic [WAYS-1:0][XLEN-1:0]  CDB_Data,
    output logic [WAYS-1:0][TW-1:0]    CDB_PRF_idx,
    output logic [CW-1:0]              count
);

    logic [DEPTH-1:0][XLEN-1:0] ent_data;
    logic [DEPTH-1:0][TW-1:0]   ent_tag;
    logic [PW-1:0]              head, tail;

    logic [CW-1:0]              avail_clip, n_deq, n_enq;
    logic [CW:0]                free_slots;
    logic [WAYS-1:0]            accept;
    logic [WAYS-1:0][PW-1:0]    wr_idx, rd_idx;

    // Pointer arithmetic for a DEPTH that need not be a power of two.
    // Callers never pass more than 2*DEPTH-1, so one subtraction suffices.
    function automatic logic [PW-1:0] wrap(input int p);
        if (p >= DEPTH) return PW'(p - DEPTH);
        return PW'(p);
    endfunction

    // Dequeue count and backpressure depend only on registered state and
    // cdb_avail, never on fu_*.
    always_comb begin
        avail_clip = (int'(cdb_avail) > WAYS) ? CW'(WAYS) : CW'(cdb_avail);
        n_deq      = (count < avail_clip) ? count : avail_clip;
        // Slots freed by this cycle's dequeue are reusable this cycle.
        free_slots = (CW+1)'(DEPTH) - {1'b0, count} + {1'b0, n_deq};
        for (int i = 0; i < WAYS; i++)
            ALU_occupied[i] = free_slots < (CW+1)'(i + 1);
    end

    // Accepted ways are compressed onto consecutive slots from tail,
    // lower way first.
    always_comb begin
        int off;
        off    = 0;
        accept = '0;
        wr_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            accept[i] = fu_valid[i] & ~ALU_occupied[i];
            wr_idx[i] = wrap(int'(tail) + off);
            if (accept[i]) off++;
        end
        n_enq = CW'(off);
    end

    for (genvar k = 0; k < WAYS; k++) begin : g_lane
        assign rd_idx[k]      = wrap(int'(head) + k);
        assign CDB_valid[k]   = CW'(k) < n_deq;
        assign CDB_Data[k]    = CDB_valid[k] ? ent_data[rd_idx[k]] : '0;
        assign CDB_PRF_idx[k] = CDB_valid[k] ? ent_tag[rd_idx[k]]  : '0;
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= wrap(int'(head) + int'(n_deq));
            tail  <= wrap(int'(tail) + int'(n_enq));
            count <= count - n_deq + n_enq;
        end
    end

    // Entry contents are don't-care after reset/squash, so the array
    // carries no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS; i++) begin
            if (accept[i]) begin
                ent_data[wr_idx[i]] <= fu_data[i];
                ent_tag[wr_idx[i]]  <= fu_prf_idx[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcast_buffer.sv
// Testbench for cdb_broadcast_buffer (WAYS=3, DEPTH=8).
// Directed vector table, hand-written wrap-around and squash sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_cdb_broadcast_buffer;

    localparam int WAYS  = 3;
    localparam int XLEN  = 32;
    localparam int PRF   = 64;
    localparam int DEPTH = 8;

    logic                      clock = 1'b0;
    logic                      reset, squash;
    logic [WAYS-1:0]           fu_valid;
    logic [WAYS-1:0][XLEN-1:0] fu_data;
    logic [WAYS-1:0][5:0]      fu_prf_idx;
    logic [2:0]                cdb_avail;
    logic [WAYS-1:0]           ALU_occupied;
    logic [WAYS-1:0]           CDB_valid;
    logic [WAYS-1:0][XLEN-1:0] CDB_Data;
    logic [WAYS-1:0][5:0]      CDB_PRF_idx;
    logic [3:0]                count;

    cdb_broadcast_buffer #(.WAYS(WAYS), .XLEN(XLEN), .PRF(PRF), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .fu_valid     (fu_valid),
        .fu_data      (fu_data),
        .fu_prf_idx   (fu_prf_idx),
        .cdb_avail    (cdb_avail),
        .ALU_occupied (ALU_occupied),
        .CDB_valid    (CDB_valid),
        .CDB_Data     (CDB_Data),
        .CDB_PRF_idx  (CDB_PRF_idx),
        .count        (count)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Directed vectors: way w carries tag tb+w and data tb+w+5.
    // Expected values are the outputs observed during the row's cycle,
    // i.e. the state left by the previous row's edge.
    typedef struct {
        logic       chk_en;
        logic       rst;
        logic       sq;
        logic [2:0] fv;
        logic [2:0] avail;
        logic [5:0] tb;
        logic [3:0] e_cnt;
        logic [2:0] e_cv;
        logic [2:0] e_occ;
        logic [5:0] e_t0;
        logic [5:0] e_t1;
    } vec_t;

    vec_t vecs[18];

    // Reference model: a plain FIFO of accepted results.
    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  t;
    } ent_t;

    ent_t       mq[$];
    logic [5:0] tag_ctr = '0;
    logic       log_en  = 1'b0;
    logic [5:0] acc_log[$];
    logic [5:0] bc_log[$];

    task automatic mstep(input logic rst, input logic sq, input logic [2:0] fv, input logic [2:0] avail);
        int n, fr, av;
        logic [2:0] occ_e;
        @(negedge clock);
        reset    = rst;
        squash   = sq;
        fu_valid = fv;
        cdb_avail = avail;
        for (int w = 0; w < WAYS; w++) begin
            fu_prf_idx[w] = tag_ctr;
            fu_data[w]    = $urandom;
            tag_ctr       = tag_ctr + 6'd1;
        end
        #1;
        av = (int'(avail) > WAYS) ? WAYS : int'(avail);
        n  = (mq.size() < av) ? mq.size() : av;
        fr = DEPTH - mq.size() + n;
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_count_le_depth", 64'(count <= 4'd8), 64'd1);
        for (int k = 0; k < WAYS; k++) begin
            chk("m_cdb_valid", 64'(CDB_valid[k]), 64'(k < n));
            chk("m_cdb_data", 64'(CDB_Data[k]), (k < n) ? 64'(mq[k].d) : 64'd0);
            chk("m_cdb_tag", 64'(CDB_PRF_idx[k]), (k < n) ? 64'(mq[k].t) : 64'd0);
        end
        for (int i = 0; i < WAYS; i++) occ_e[i] = (fr < i + 1);
        chk("m_occupied", 64'(ALU_occupied), 64'(occ_e));
        if (log_en)
            for (int k = 0; k < WAYS; k++)
                if (CDB_valid[k]) bc_log.push_back(CDB_PRF_idx[k]);
        @(posedge clock);
        if (rst || sq) begin
            mq.delete();
        end else begin
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            for (int i = 0; i < WAYS; i++)
                if (fv[i] && !occ_e[i]) begin
                    mq.push_back('{d: fu_data[i], t: fu_prf_idx[i]});
                    if (log_en) acc_log.push_back(fu_prf_idx[i]);
                end
        end
    endtask

    initial begin
        logic [2:0] av_cycle[4];
        int cyc, rem;
        logic [2:0] fv;
        logic [5:0] bv;

        reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_data = '0;
        fu_prf_idx = '0; cdb_avail = '0;

        //             chk rst sq  fv      av    tb     cnt  cv      occ     t0     t1
        vecs[0]  = '{1'b0,1'b1,1'b0,3'b111,3'd3,6'd0 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[1]  = '{1'b1,1'b1,1'b0,3'b111,3'd3,6'd0 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[2]  = '{1'b1,1'b0,1'b0,3'b010,3'd3,6'd4 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[3]  = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd1,3'b001,3'b000,6'd5 ,6'd0 };
        vecs[4]  = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[5]  = '{1'b1,1'b0,1'b0,3'b111,3'd0,6'd10,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[6]  = '{1'b1,1'b0,1'b0,3'b111,3'd0,6'd13,4'd3,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[7]  = '{1'b1,1'b0,1'b0,3'b111,3'd0,6'd16,4'd6,3'b000,3'b100,6'd0 ,6'd0 };
        vecs[8]  = '{1'b1,1'b0,1'b0,3'b111,3'd0,6'd20,4'd8,3'b000,3'b111,6'd0 ,6'd0 };
        vecs[9]  = '{1'b1,1'b0,1'b0,3'b000,3'd2,6'd0 ,4'd8,3'b011,3'b100,6'd10,6'd11};
        vecs[10] = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd6,3'b111,3'b000,6'd12,6'd13};
        vecs[11] = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd3,3'b111,3'b000,6'd15,6'd16};
        vecs[12] = '{1'b1,1'b0,1'b0,3'b101,3'd0,6'd30,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[13] = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd2,3'b011,3'b000,6'd30,6'd32};
        vecs[14] = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[15] = '{1'b1,1'b0,1'b0,3'b111,3'd7,6'd40,4'd0,3'b000,3'b000,6'd0 ,6'd0 };
        vecs[16] = '{1'b1,1'b0,1'b0,3'b000,3'd7,6'd0 ,4'd3,3'b111,3'b000,6'd40,6'd41};
        vecs[17] = '{1'b1,1'b0,1'b0,3'b000,3'd3,6'd0 ,4'd0,3'b000,3'b000,6'd0 ,6'd0 };

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            reset     = vecs[i].rst;
            squash    = vecs[i].sq;
            fu_valid  = vecs[i].fv;
            cdb_avail = vecs[i].avail;
            for (int w = 0; w < WAYS; w++) begin
                fu_prf_idx[w] = 6'(int'(vecs[i].tb) + w);
                fu_data[w]    = 32'(int'(vecs[i].tb) + w + 5);
            end
            #1;
            if (vecs[i].chk_en) begin
                chk("vec_count", 64'(count), 64'(vecs[i].e_cnt));
                chk("vec_cdb_valid", 64'(CDB_valid), 64'(vecs[i].e_cv));
                chk("vec_occupied", 64'(ALU_occupied), 64'(vecs[i].e_occ));
                chk("vec_tag0", 64'(CDB_PRF_idx[0]), 64'(vecs[i].e_t0));
                chk("vec_tag1", 64'(CDB_PRF_idx[1]), 64'(vecs[i].e_t1));
                chk("vec_data0", 64'(CDB_Data[0]),
                    vecs[i].e_cv[0] ? 64'(vecs[i].e_t0) + 64'd5 : 64'd0);
            end
        end

        // Wrap-around: 20 tagged results with cdb_avail cycling 3,1,0,2.
        av_cycle[0] = 3'd3; av_cycle[1] = 3'd1; av_cycle[2] = 3'd0; av_cycle[3] = 3'd2;
        log_en = 1'b1;
        cyc = 0;
        while (acc_log.size() < 20 && cyc < 200) begin
            rem = 20 - acc_log.size();
            fv  = (rem >= 3) ? 3'b111 : (rem == 2) ? 3'b011 : 3'b001;
            mstep(1'b0, 1'b0, fv, av_cycle[cyc % 4]);
            cyc++;
        end
        cyc = 0;
        while (mq.size() > 0 && cyc < 50) begin
            mstep(1'b0, 1'b0, 3'b000, 3'd3);
            cyc++;
        end
        log_en = 1'b0;
        chk("wrap_accepted", 64'(acc_log.size()), 64'd20);
        chk("wrap_drained", 64'(mq.size()), 64'd0);
        chk("wrap_bcast_len", 64'(bc_log.size()), 64'(acc_log.size()));
        for (int i = 0; i < acc_log.size(); i++) begin
            bv = (i < bc_log.size()) ? bc_log[i] : 6'h3f;
            chk("wrap_order", 64'(bv), 64'(acc_log[i]));
        end

        // Squash at count 5 with all three ways presenting results.
        mstep(1'b0, 1'b0, 3'b111, 3'd0);
        mstep(1'b0, 1'b0, 3'b011, 3'd0);
        mstep(1'b0, 1'b1, 3'b111, 3'd3);
        @(negedge clock);
        squash = 1'b0; fu_valid = '0; cdb_avail = 3'd3;
        #1;
        chk("squash_count", 64'(count), 64'd0);
        chk("squash_cdb_valid", 64'(CDB_valid), 64'd0);
        chk("squash_occupied", 64'(ALU_occupied), 64'd0);
        @(posedge clock);
        mstep(1'b0, 1'b0, 3'b000, 3'd3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            mstep($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                  3'($urandom), 3'($urandom_range(0, 7)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
